// File: rtl/adc_slice_capture.sv
`timescale 1ns/1ps
// adc_slice_capture
//
// Purpose:
//   Consumes one stochastic ADC slice on the emulator clock. Rising edges of
//   the slice sample clock (clk_adder) are detected as data. On each edge the
//   sign/magnitude sample is converted to two's complement, an offset is
//   subtracted, the result is saturated and presented with a one-cycle strobe.
//   A calibration FSM averages 2^CAL_LOG2 raw samples to estimate the offset.
//
// Ports:
//   emu_clk     in   emulator clock (only clock)
//   emu_rst     in   synchronous active-high reset
//   clk_adder   in   slice sample clock, treated as data
//   en          in   capture enable (edges ignored when low)
//   sign_in     in   slice sign, 1 = positive
//   mag_in      in   [Nadc]    unsigned slice magnitude
//   offset_ext  in   [Nadc+1]  signed external offset
//   use_est     in   1 = subtract offset_est, 0 = subtract offset_ext
//   cal_start   in   single-cycle calibration request
//   data_out    out  [Nadc+1]  signed corrected sample
//   data_valid  out  one-cycle strobe, data_out is new
//   offset_est  out  [Nadc+1]  signed calibration result
//   cal_busy    out  high while accumulating
//   cal_done    out  high in DONE state
module adc_slice_capture #(
  parameter int Nadc     = 8,
  parameter int CAL_LOG2 = 6
) (
  input  logic                   emu_clk,
  input  logic                   emu_rst,
  input  logic                   clk_adder,
  input  logic                   en,
  input  logic                   sign_in,
  input  logic [Nadc-1:0]        mag_in,
  input  logic signed [Nadc:0]   offset_ext,
  input  logic                   use_est,
  input  logic                   cal_start,
  output logic signed [Nadc:0]   data_out,
  output logic                   data_valid,
  output logic signed [Nadc:0]   offset_est,
  output logic                   cal_busy,
  output logic                   cal_done
);

  localparam int DW = Nadc + 1;            // sample width
  localparam int CW = Nadc + 2;            // correction width, before saturation
  localparam int AW = Nadc + 1 + CAL_LOG2; // accumulator width, cannot overflow
  localparam int NW = CAL_LOG2 + 1;        // sample counter width
  localparam logic [NW-1:0] CNT_LAST = NW'((1 << CAL_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Clamp a CW-bit value into the DW-bit signed range. Overflow is present
  // exactly when the two top bits disagree.
  function automatic logic signed [DW-1:0] sat(input logic signed [CW-1:0] x);
    if (x[CW-1] != x[CW-2])
      sat = x[CW-1] ? {1'b1, {Nadc{1'b0}}} : {1'b0, {Nadc{1'b1}}};
    else
      sat = x[DW-1:0];
  endfunction

  state_t                 state_q;
  logic                   clk_adder_q;
  logic                   vld_q;
  logic signed [DW-1:0]   data_q;
  logic signed [DW-1:0]   est_q;
  logic signed [AW-1:0]   acc_q;
  logic [NW-1:0]          cnt_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   cap_edge_d;
  logic signed [DW-1:0]   mag_s_d;
  logic signed [DW-1:0]   raw_d;
  logic signed [DW-1:0]   off_d;
  logic signed [CW-1:0]   corr_d;
  logic signed [AW-1:0]   acc_d;

  always_comb begin
    cap_edge_d = clk_adder & ~clk_adder_q & en;
    mag_s_d    = $signed({1'b0, mag_in});
    raw_d      = sign_in ? mag_s_d : -mag_s_d;
    off_d      = use_est ? est_q : offset_ext;
    corr_d     = $signed({raw_d[DW-1], raw_d}) - $signed({off_d[DW-1], off_d});
    acc_d      = acc_q + $signed({{CAL_LOG2{raw_d[DW-1]}}, raw_d});
  end

  // Capture stage and calibration FSM. clk_adder_q resets to 1 so a high
  // sample clock at reset release is not mistaken for a rising edge.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      clk_adder_q <= 1'b1;
      vld_q       <= 1'b0;
      data_q      <= '0;
      est_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      state_q     <= IDLE;
    end else begin
      clk_adder_q <= clk_adder;
      vld_q       <= cap_edge_d;
      if (cap_edge_d)
        data_q <= sat(corr_d);

      case (state_q)
        IDLE: begin
          if (cal_start) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ACCUM: begin
          if (cap_edge_d) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + NW'(1);
            if (cnt_q == CNT_LAST) begin
              // Arithmetic shift of the full sum (floor); top DW bits of the
              // shifted value are the mean.
              est_q   <= acc_d[AW-1:CAL_LOG2];
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (cal_start) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = vld_q;
  assign offset_est = est_q;
  assign cal_busy   = busy_q;
  assign cal_done   = done_q;

endmodule

// File: tb/tb_adc_slice_capture.sv
`timescale 1ns/1ps
module tb_adc_slice_capture;

  logic              emu_clk = 1'b0;
  logic              emu_rst;
  logic              clk_adder;
  logic              en;
  logic              sign_in;
  logic [7:0]        mag_in;
  logic signed [8:0] offset_ext;
  logic              use_est;
  logic              cal_start;
  logic signed [8:0] data_out;
  logic              data_valid;
  logic signed [8:0] offset_est;
  logic              cal_busy;
  logic              cal_done;

  adc_slice_capture #(.Nadc(8), .CAL_LOG2(6)) dut (
    .emu_clk   (emu_clk),
    .emu_rst   (emu_rst),
    .clk_adder (clk_adder),
    .en        (en),
    .sign_in   (sign_in),
    .mag_in    (mag_in),
    .offset_ext(offset_ext),
    .use_est   (use_est),
    .cal_start (cal_start),
    .data_out  (data_out),
    .data_valid(data_valid),
    .offset_est(offset_est),
    .cal_busy  (cal_busy),
    .cal_done  (cal_done)
  );

  always #5 emu_clk = ~emu_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge emu_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference: sign/magnitude to signed, subtract, clamp.
  function automatic int model(input bit s, input int m, input int off);
    int r;
    r = (s ? m : -m) - off;
    if (r > 255)  r = 255;
    if (r < -256) r = -256;
    return r;
  endfunction

  // Scoreboard: expected value and the cycle its strobe must appear in.
  typedef struct {
    int due;
    int val;
  } exp_t;
  exp_t sbq[$];

  always @(negedge emu_clk) begin
    exp_t e;
    if (data_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("sb_cycle", cyc, e.due);
        chk("sb_data", int'(data_out), e.val);
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("sb_missing_valid", 0, 1);
    end
  end

  // One clk_adder period: high one cycle (edge seen at next posedge), low one.
  task automatic do_edge(input bit s, input int m, input bit push, input int v);
    exp_t e;
    @(posedge emu_clk); #1;
    sign_in   = s;
    mag_in    = 8'(m);
    clk_adder = 1'b1;
    if (push) begin
      e.due = cyc + 1;
      e.val = v;
      sbq.push_back(e);
    end
    @(posedge emu_clk); #1;
    clk_adder = 1'b0;
  endtask

  task automatic pulse_cal;
    @(posedge emu_clk); #1;
    cal_start = 1'b1;
    @(posedge emu_clk); #1;
    cal_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge emu_clk);
    #1;
  endtask

  typedef struct {
    bit s;
    int m;
    int off;
    int exp;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 100,    0,  100};
    tbl[1]  = '{1'b0, 100,    0, -100};
    tbl[2]  = '{1'b1, 255,  -10,  255};
    tbl[3]  = '{1'b0, 255,   10, -256};
    tbl[4]  = '{1'b0,   0,    5,   -5};
    tbl[5]  = '{1'b1,   0,    5,   -5};
    tbl[6]  = '{1'b1, 255,    0,  255};
    tbl[7]  = '{1'b0, 255,    0, -255};
    tbl[8]  = '{1'b1,  50, -200,  250};
    tbl[9]  = '{1'b0,  50,  200, -250};
    tbl[10] = '{1'b1, 200, -100,  255};
    tbl[11] = '{1'b0, 128,  128, -256};

    // Reset with clk_adder held high through release.
    emu_rst = 1'b1; clk_adder = 1'b1; en = 1'b1; sign_in = 1'b1; mag_in = '0;
    offset_ext = '0; use_est = 1'b0; cal_start = 1'b0;
    idle(4);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_offset_est", int'(offset_est), 0);
    chk("rst_cal_busy", int'(cal_busy), 0);
    chk("rst_cal_done", int'(cal_done), 0);
    emu_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("no_edge_at_release", int'(data_valid), 0);
    end
    clk_adder = 1'b0;
    idle(2);

    // Table-driven conversion, correction and saturation.
    for (int i = 0; i < 12; i++) begin
      offset_ext = 9'(tbl[i].off);
      do_edge(tbl[i].s, tbl[i].m, 1'b1, tbl[i].exp);
    end
    idle(3);

    // Calibration: 64 samples of +7.
    offset_ext = '0; use_est = 1'b0;
    pulse_cal;
    chk("cal_busy_start", int'(cal_busy), 1);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) chk("busy_before_last", int'(cal_busy), 1);
      do_edge(1'b1, 7, 1'b1, model(1'b1, 7, 0));
    end
    chk("cal_done_7", int'(cal_done), 1);
    chk("cal_busy_end_7", int'(cal_busy), 0);
    chk("offset_est_7", int'(offset_est), 7);
    use_est = 1'b1;
    do_edge(1'b1, 7, 1'b1, 0);
    do_edge(1'b1, 20, 1'b1, 13);
    use_est = 1'b0;
    idle(3);

    // Floor rounding, cal_start ignored in ACCUM.
    pulse_cal;
    chk("done_drops", int'(cal_done), 0);
    chk("busy_restart", int'(cal_busy), 1);
    for (int i = 0; i < 32; i++) begin
      do_edge(1'b0, 1, 1'b1, -1);
      if (i == 15) pulse_cal;
    end
    for (int i = 0; i < 32; i++) do_edge(1'b1, 0, 1'b1, 0);
    chk("cal_done_floor", int'(cal_done), 1);
    chk("offset_est_floor", int'(offset_est), -1);
    use_est = 1'b1;
    do_edge(1'b1, 10, 1'b1, 11);
    use_est = 1'b0;
    idle(3);

    // en=0 pauses calibration: 3 ignored edges must not count.
    pulse_cal;
    for (int i = 0; i < 10; i++) do_edge(1'b1, 4, 1'b1, 4);
    en = 1'b0;
    for (int i = 0; i < 3; i++) do_edge(1'b0, 100, 1'b0, 0);
    en = 1'b1;
    for (int i = 0; i < 53; i++) do_edge(1'b1, 4, 1'b1, 4);
    chk("paused_not_done", int'(cal_done), 0);
    do_edge(1'b1, 4, 1'b1, 4);
    chk("paused_done", int'(cal_done), 1);
    chk("offset_est_4", int'(offset_est), 4);
    idle(3);

    // Reset mid-ACCUM, with an edge arriving in the reset cycle.
    pulse_cal;
    for (int i = 0; i < 5; i++) do_edge(1'b1, 9, 1'b1, 9);
    idle(2);
    emu_rst = 1'b1; clk_adder = 1'b1;
    idle(1);
    chk("midrst_busy", int'(cal_busy), 0);
    chk("midrst_offset_est", int'(offset_est), 0);
    chk("midrst_data_out", int'(data_out), 0);
    chk("midrst_valid", int'(data_valid), 0);
    emu_rst = 1'b0;
    idle(2);
    clk_adder = 1'b0;
    chk("post_rst_valid", int'(data_valid), 0);
    use_est = 1'b1;
    do_edge(1'b1, 5, 1'b1, 5);
    use_est = 1'b0;
    idle(4);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
